sysid_check_master: RTL and testbench

- Avalon-MM read master that queries the system-ID slave. Word 0 is the system ID and word 1 is the build timestamp.
- It compares both words against expected values and publishes the captured words plus pass/fail/timeout status.
- It sits beside the boot controller on the SoC control bus. A bring-up test or an LED can gate on pass before software runs.

---
 rtl/sysid_check_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_sysid_check_master.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// -----------------------------------------------------------------------------
// sysid_check_master
//
// Avalon-MM read master that reads the two words of a system-ID slave
// (word 0 = system ID, word 1 = build timestamp), compares them with the
// expected values and publishes the captured words plus pass/fail/timeout
// status. A bring-up test or a status LED can gate on `pass` before software
// is allowed to run.
//
// Ports
//   clock            system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            single-cycle request to run a check (ignored while busy)
//   avm_address      word select: 0 = ID, 1 = timestamp
//   avm_read         Avalon read strobe
//   avm_waitrequest  slave stall (tie 0 for slaves without stall)
//   avm_readdata     slave read data
//   busy             check in progress
//   done             level, high from completion until next start or reset
//   pass             id_ok & ts_ok & ~timeout, valid while done
//   id_ok / ts_ok    captured word equals its expected value
//   timeout          a read saw TIMEOUT_CYCLES consecutive stall cycles
//   id_value         captured word 0
//   ts_value         captured word 1
// -----------------------------------------------------------------------------
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1710942803,
  parameter int unsigned READ_LATENCY       = 0,   // legal 0..3
  parameter int unsigned TIMEOUT_CYCLES     = 16,  // legal 1..255
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_LAT_ID,
    S_REQ_TS,
    S_LAT_TS,
    S_DONE
  } state_e;

  // Last stall count before the read is abandoned, and the latency counter
  // load value (data is sampled when the counter is already at zero, hence -1).
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_LOAD  = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam bit         ZERO_LAT  = (READ_LATENCY == 0);

  state_e      state_q, state_d;
  logic        auto_q, auto_d;        // one-shot "start after reset" request
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic launch;   // begin a new check this edge
  logic finish;   // timestamp captured this edge
  logic to_hit;   // stall limit reached this edge

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    lat_cnt_d  = lat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    launch     = 1'b0;
    finish     = 1'b0;
    to_hit     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start || auto_q) launch = 1'b1;
      end

      S_REQ_ID: begin
        if (avm_waitrequest) begin
          if (wait_cnt_q == WAIT_LAST) to_hit = 1'b1;
          else                         wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = '0;
          if (ZERO_LAT) begin
            id_value_d = avm_readdata;
            state_d    = S_REQ_TS;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = S_LAT_ID;
          end
        end
      end

      S_LAT_ID: begin
        if (lat_cnt_q == 2'd0) begin
          id_value_d = avm_readdata;
          state_d    = S_REQ_TS;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      S_REQ_TS: begin
        if (avm_waitrequest) begin
          if (wait_cnt_q == WAIT_LAST) to_hit = 1'b1;
          else                         wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = '0;
          if (ZERO_LAT) begin
            ts_value_d = avm_readdata;
            finish     = 1'b1;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = S_LAT_TS;
          end
        end
      end

      S_LAT_TS: begin
        if (lat_cnt_q == 2'd0) begin
          ts_value_d = avm_readdata;
          finish     = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      S_DONE: begin
        if (start) launch = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // A new check clears all published results on the same edge.
    if (launch) begin
      state_d    = S_REQ_ID;
      auto_d     = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      timeout_d  = 1'b0;
      id_value_d = '0;
      ts_value_d = '0;
      wait_cnt_d = '0;
      lat_cnt_d  = '0;
    end

    // Verdict is registered together with the final capture (or the abort),
    // so the *_d capture values are the ones compared. An abandoned read
    // leaves the unread word at 0 and forces both ok flags low.
    if (finish || to_hit) begin
      state_d    = S_DONE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      timeout_d  = to_hit;
      wait_cnt_d = '0;
      id_ok_d    = !to_hit && (id_value_d == EXPECTED_ID);
      ts_ok_d    = !to_hit && (ts_value_d == EXPECTED_TIMESTAMP);
      pass_d     = id_ok_d && ts_ok_d;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      auto_q     <= AUTO_START;
      lat_cnt_q  <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      lat_cnt_q  <= lat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Bus strobes are a pure decode of the registered state, so they are
  // glitch-free and stay stable for as long as the slave stalls.
  assign avm_read    = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
  assign avm_address = (state_q == S_REQ_TS) || (state_q == S_LAT_TS);

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_master
//
// Two instances share one clock:
//   instance 0: READ_LATENCY=0, TIMEOUT_CYCLES=16, EXPECTED_ID=0
//   instance 1: READ_LATENCY=2, TIMEOUT_CYCLES=4,  EXPECTED_ID=32'h5EED0001
// Each has its own system-ID slave model with programmable stalls, a stuck
// waitrequest option and random garbage on readdata outside valid data cycles.
// Expected results come from a per-read timing/result model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sysid_check_master;

  localparam logic [31:0] EXP_TS  = 32'h65FA_EA53;
  localparam logic [31:0] EXP_ID1 = 32'h5EED_0001;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic int tmo_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction
  function automatic logic [31:0] exp_id_of(input int i);
    return (i == 0) ? 32'd0 : EXP_ID1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  logic        rst [2];
  logic        start [2];
  logic        avm_address [2];
  logic        avm_read [2];
  logic        wr [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic        id_ok [2];
  logic        ts_ok [2];
  logic        timeout [2];
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];

  // Slave configuration (written by the stimulus only)
  logic [31:0] word0 [2];
  logic [31:0] word1 [2];
  int          stall0 [2];
  int          stall1 [2];
  bit          stuck [2];

  // Slave state and bus log (written by the slave model only)
  int          cyc;
  int          stall_seen [2];
  int          pend_due [2];
  logic [31:0] pend_data [2];
  int          rd_cycles [2];
  int          acc_cnt [2];
  int          hold_bad [2];
  logic        acc_addr [2][64];
  int          acc_edge [2][64];
  bit          prev_stall [2];
  logic        prev_addr [2];
  logic [31:0] garbage [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sysid_check_master #(
      .EXPECTED_ID        ((g == 0) ? 32'd0 : EXP_ID1),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .READ_LATENCY       ((g == 0) ? 0 : 2),
      .TIMEOUT_CYCLES     ((g == 0) ? 16 : 4),
      .AUTO_START         (1'b1)
    ) u_dut (
      .clock           (clk),
      .reset           (rst[g]),
      .start           (start[g]),
      .avm_address     (avm_address[g]),
      .avm_read        (avm_read[g]),
      .avm_waitrequest (wr[g]),
      .avm_readdata    (rdata[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .id_ok           (id_ok[g]),
      .ts_ok           (ts_ok[g]),
      .timeout         (timeout[g]),
      .id_value        (id_value[g]),
      .ts_value        (ts_value[g])
    );

    assign wr[g] = stuck[g] |
                   (avm_read[g] & (stall_seen[g] < (avm_address[g] ? stall1[g] : stall0[g])));

    // Zero latency: data valid in the accepting cycle. Otherwise data valid
    // only in the cycle that ends on the due edge; garbage at all other times.
    assign rdata[g] = (lat_of(g) == 0)
                    ? ((avm_read[g] && !wr[g]) ? (avm_address[g] ? word1[g] : word0[g]) : garbage[g])
                    : ((cyc + 1 == pend_due[g]) ? pend_data[g] : garbage[g]);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) garbage[i] = $urandom;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      prev_stall[i] <= 1'b0;
      if (rst[i]) begin
        stall_seen[i] <= 0;
      end else begin
        // While stalled below the limit, read and address must not move.
        if (prev_stall[i] && stall_seen[i] < tmo_of(i) &&
            (!avm_read[i] || avm_address[i] != prev_addr[i]))
          hold_bad[i] <= hold_bad[i] + 1;
        if (avm_read[i]) begin
          rd_cycles[i] <= rd_cycles[i] + 1;
          if (wr[i]) begin
            stall_seen[i] <= stall_seen[i] + 1;
            prev_stall[i] <= 1'b1;
            prev_addr[i]  <= avm_address[i];
          end else begin
            stall_seen[i] <= 0;
            acc_addr[i][acc_cnt[i] % 64] <= avm_address[i];
            acc_edge[i][acc_cnt[i] % 64] <= cyc + 1;
            acc_cnt[i]    <= acc_cnt[i] + 1;
            pend_due[i]   <= cyc + 1 + lat_of(i);
            pend_data[i]  <= avm_address[i] ? word1[i] : word0[i];
          end
        end else begin
          stall_seen[i] <= 0;
        end
      end
    end
  end

  // Expected outcome of one check from the slave configuration: every read
  // costs its stall cycles + 1 acceptance cycle + latency; a read that stalls
  // TIMEOUT cycles ends the check there. Edges counted include the edge that
  // samples start / the first edge out of reset.
  task automatic model(input int i, output int edges, output int rd, output int nacc,
                       output logic [31:0] id_v, output logic [31:0] ts_v,
                       output logic idok, output logic tsok, output logic to_f,
                       output logic ps);
    int t;
    int l;
    int s0;
    int s1;
    t  = tmo_of(i);
    l  = lat_of(i);
    s0 = stuck[i] ? t : stall0[i];
    s1 = stuck[i] ? t : stall1[i];
    edges = 1; rd = 0; nacc = 0; id_v = '0; ts_v = '0; to_f = 1'b0;
    if (s0 >= t) begin
      edges += t; rd += t; to_f = 1'b1;
    end else begin
      edges += s0 + 1 + l; rd += s0 + 1; nacc++; id_v = word0[i];
      if (s1 >= t) begin
        edges += t; rd += t; to_f = 1'b1;
      end else begin
        edges += s1 + 1 + l; rd += s1 + 1; nacc++; ts_v = word1[i];
      end
    end
    idok = !to_f && (id_v == exp_id_of(i));
    tsok = !to_f && (ts_v == EXP_TS);
    ps   = idok && tsok;
  endtask

  // Stimulus must have been applied just after a posedge (at a negedge).
  // Returns the number of edges until done is seen, or -1 on expiry.
  task automatic wait_done(input int i, input int limit, output int edges);
    edges = 0;
    while (1) begin
      @(negedge clk);
      edges++;
      start[i] = 1'b0;
      if (done[i] === 1'b1) return;
      if (edges >= limit) begin
        edges = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [71:0] snap;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      snap = {avm_read[i], avm_address[i], busy[i], done[i], pass[i], id_ok[i],
              ts_ok[i], timeout[i], id_value[i], ts_value[i]};
      tests_run++;
      if (snap !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", i, snap);
      end
    end
  endtask

  task automatic test_auto_start();
    int edges;
    int b_rd;
    int b_acc;
    b_rd = rd_cycles[0]; b_acc = acc_cnt[0];
    rst[0] = 1'b0;
    wait_done(0, 40, edges);
    tests_run++;
    if (edges !== 3) begin tests_failed++; $display("FAIL auto_latency: got %0d expected 3", edges); end
    tests_run++;
    if ({done[0], pass[0], id_ok[0], ts_ok[0], timeout[0]} !== 5'b11110) begin
      tests_failed++;
      $display("FAIL auto_status: got %b expected 11110", {done[0], pass[0], id_ok[0], ts_ok[0], timeout[0]});
    end
    tests_run++;
    if (id_value[0] !== 32'd0 || ts_value[0] !== EXP_TS) begin
      tests_failed++;
      $display("FAIL auto_values: got %h/%h expected 00000000/%h", id_value[0], ts_value[0], EXP_TS);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (acc_cnt[0] - b_acc !== 2 || rd_cycles[0] - b_rd !== 2) begin
      tests_failed++;
      $display("FAIL auto_read_count: got acc=%0d rd=%0d expected 2/2", acc_cnt[0] - b_acc, rd_cycles[0] - b_rd);
    end
    tests_run++;
    if (acc_addr[0][b_acc % 64] !== 1'b0 || acc_addr[0][(b_acc + 1) % 64] !== 1'b1 ||
        acc_edge[0][(b_acc + 1) % 64] - acc_edge[0][b_acc % 64] !== 1) begin
      tests_failed++;
      $display("FAIL auto_read_order: got addr %b,%b gap %0d expected 0,1 gap 1",
               acc_addr[0][b_acc % 64], acc_addr[0][(b_acc + 1) % 64],
               acc_edge[0][(b_acc + 1) % 64] - acc_edge[0][b_acc % 64]);
    end
  endtask

  task automatic test_ts_mismatch();
    int edges;
    word1[0] = 32'd1710942802;
    start[0] = 1'b1;
    wait_done(0, 40, edges);
    tests_run++;
    if (edges !== 3) begin tests_failed++; $display("FAIL mismatch_latency: got %0d expected 3", edges); end
    tests_run++;
    if ({done[0], id_ok[0], ts_ok[0], pass[0]} !== 4'b1100 || ts_value[0] !== 32'd1710942802) begin
      tests_failed++;
      $display("FAIL mismatch_status: got %b ts=%0d expected 1100 ts=1710942802",
               {done[0], id_ok[0], ts_ok[0], pass[0]}, ts_value[0]);
    end
    word1[0] = EXP_TS;
  endtask

  task automatic test_stall_hold();
    int edges;
    int b_hold;
    int b_rd;
    b_hold = hold_bad[0]; b_rd = rd_cycles[0];
    stall0[0] = 5; stall1[0] = 5;
    start[0] = 1'b1;
    wait_done(0, 60, edges);
    tests_run++;
    if (edges !== 13) begin tests_failed++; $display("FAIL stall_latency: got %0d expected 13", edges); end
    tests_run++;
    if (pass[0] !== 1'b1 || timeout[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_pass: got pass=%b timeout=%b expected 1/0", pass[0], timeout[0]);
    end
    tests_run++;
    if (hold_bad[0] - b_hold !== 0 || rd_cycles[0] - b_rd !== 12) begin
      tests_failed++;
      $display("FAIL stall_hold: got moves=%0d rd=%0d expected 0/12", hold_bad[0] - b_hold, rd_cycles[0] - b_rd);
    end
    stall0[0] = 0; stall1[0] = 0;
  endtask

  task automatic test_latency_and_reset();
    int edges;
    int b_rd;
    b_rd = rd_cycles[1];
    rst[1] = 1'b0;
    wait_done(1, 40, edges);
    tests_run++;
    if (edges !== 7) begin tests_failed++; $display("FAIL lat_auto_latency: got %0d expected 7", edges); end
    tests_run++;
    if (pass[1] !== 1'b1 || id_value[1] !== EXP_ID1 || ts_value[1] !== EXP_TS) begin
      tests_failed++;
      $display("FAIL lat_capture: got pass=%b %h/%h expected 1 %h/%h", pass[1], id_value[1], ts_value[1], EXP_ID1, EXP_TS);
    end

    // A start pulse while in LAT_ID must neither restart nor queue a check.
    b_rd = rd_cycles[1];
    start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0; edges = 1;
    repeat (2) begin @(negedge clk); edges++; end
    start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0; edges++;
    while (done[1] !== 1'b1 && edges < 60) begin @(negedge clk); edges++; end
    repeat (6) @(negedge clk);
    tests_run++;
    if (edges !== 7 || rd_cycles[1] - b_rd !== 2 || pass[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: got edges=%0d rd=%0d pass=%b expected 7/2/1", edges, rd_cycles[1] - b_rd, pass[1]);
    end

    // Reset while in LAT_TS clears everything on the next cycle.
    start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy[1] !== 1'b1 || avm_address[1] !== 1'b1 || id_value[1] !== EXP_ID1) begin
      tests_failed++;
      $display("FAIL lat_ts_midcheck: got busy=%b addr=%b id=%h expected 1/1/%h", busy[1], avm_address[1], id_value[1], EXP_ID1);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({avm_read[1], avm_address[1], busy[1], done[1], pass[1], id_ok[1], ts_ok[1], timeout[1]} !== 8'd0 ||
        id_value[1] !== 32'd0 || ts_value[1] !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_midcheck: got %b %h/%h expected all 0",
               {avm_read[1], avm_address[1], busy[1], done[1], pass[1], id_ok[1], ts_ok[1], timeout[1]},
               id_value[1], ts_value[1]);
    end
    rst[1] = 1'b0;
    wait_done(1, 40, edges);
    tests_run++;
    if (edges !== 7 || pass[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reauto_after_reset: got edges=%0d pass=%b expected 7/1", edges, pass[1]);
    end
  endtask

  task automatic test_timeout();
    int edges;
    int b_rd;
    b_rd = rd_cycles[1];
    stuck[1] = 1'b1;
    start[1] = 1'b1;
    wait_done(1, 40, edges);
    tests_run++;
    if (edges !== 5) begin tests_failed++; $display("FAIL timeout_latency: got %0d expected 5", edges); end
    tests_run++;
    if ({done[1], timeout[1], pass[1], id_ok[1], ts_ok[1]} !== 5'b11000 ||
        id_value[1] !== 32'd0 || ts_value[1] !== 32'd0) begin
      tests_failed++;
      $display("FAIL timeout_status: got %b %h/%h expected 11000 0/0",
               {done[1], timeout[1], pass[1], id_ok[1], ts_ok[1]}, id_value[1], ts_value[1]);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (avm_read[1] !== 1'b0 || rd_cycles[1] - b_rd !== 4) begin
      tests_failed++;
      $display("FAIL timeout_read_drop: got read=%b rd=%0d expected 0/4", avm_read[1], rd_cycles[1] - b_rd);
    end
    stuck[1] = 1'b0;
  endtask

  task automatic test_random();
    int i;
    int t;
    int edges;
    int e_edges;
    int e_rd;
    int e_acc;
    int b_rd;
    int b_acc;
    int b_hold;
    logic [31:0] e_id;
    logic [31:0] e_ts;
    logic e_idok;
    logic e_tsok;
    logic e_to;
    logic e_pass;
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 1));
      t = tmo_of(i);
      stall0[i] = int'($urandom_range(0, t + 1));
      stall1[i] = int'($urandom_range(0, t + 1));
      stuck[i]  = ($urandom_range(0, 9) == 0);
      word0[i]  = exp_id_of(i);
      word1[i]  = EXP_TS;
      if ($urandom_range(0, 2) == 0) word0[i] = word0[i] ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) word1[i] = word1[i] ^ (32'd1 << $urandom_range(0, 31));
      model(i, e_edges, e_rd, e_acc, e_id, e_ts, e_idok, e_tsok, e_to, e_pass);
      b_rd = rd_cycles[i]; b_acc = acc_cnt[i]; b_hold = hold_bad[i];
      start[i] = 1'b1;
      wait_done(i, e_edges + 20, edges);
      tests_run++;
      if (edges !== e_edges) begin
        tests_failed++;
        $display("FAIL rand%0d_latency[%0d]: got %0d expected %0d", n, i, edges, e_edges);
      end
      tests_run++;
      if ({pass[i], id_ok[i], ts_ok[i], timeout[i]} !== {e_pass, e_idok, e_tsok, e_to}) begin
        tests_failed++;
        $display("FAIL rand%0d_status[%0d]: got %b expected %b", n, i,
                 {pass[i], id_ok[i], ts_ok[i], timeout[i]}, {e_pass, e_idok, e_tsok, e_to});
      end
      tests_run++;
      if (id_value[i] !== e_id || ts_value[i] !== e_ts) begin
        tests_failed++;
        $display("FAIL rand%0d_values[%0d]: got %h/%h expected %h/%h", n, i, id_value[i], ts_value[i], e_id, e_ts);
      end
      @(negedge clk);
      tests_run++;
      if (rd_cycles[i] - b_rd !== e_rd || acc_cnt[i] - b_acc !== e_acc || hold_bad[i] - b_hold !== 0) begin
        tests_failed++;
        $display("FAIL rand%0d_bus[%0d]: got rd=%0d acc=%0d moves=%0d expected %0d/%0d/0", n, i,
                 rd_cycles[i] - b_rd, acc_cnt[i] - b_acc, hold_bad[i] - b_hold, e_rd, e_acc);
      end
      stuck[i] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]    = 1'b1;
      start[i]  = 1'b0;
      word0[i]  = exp_id_of(i);
      word1[i]  = EXP_TS;
      stall0[i] = 0;
      stall1[i] = 0;
      stuck[i]  = 1'b0;
    end
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_stall_hold();
    test_latency_and_reset();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
